oam_dma_controller: RTL and testbench
=====================================

// Module: oam_dma_controller
// PURPOSE
//  Sprite (OAM) DMA sequencer. Shares the CPU address/data bus with a 256-byte page copy to the PPU OAM data port.
//  A CPU write to DMA_REG_ADDR latches the source page, halts the CPU via rdy and takes bus ownership.
//  It then issues alternating read/write cycles and returns the bus. Sits between the CPU core and the system bus mux.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU write address that triggers a transfer; written data = source page
//  OAM_DATA_ADDR  16'h2004  destination address for every DMA write
//  BYTE_COUNT     256       bytes per transfer (1..256); index width fixed at 8 bits
// PORTS
//  clk_ph2       in   1   clock phase 2; all state changes on posedge
//  rst           in   1   synchronous, active-high reset
//  cpu_addr      in   16  CPU address bus output
//  cpu_dout      in   8   CPU data output (write data)
//  cpu_we        in   1   CPU write strobe for the current cycle
//  mem_rdata     in   8   system bus read data (valid in same cycle as dma_addr)
//  rdy           out  1   0 = CPU must stall; 1 = CPU runs
//  bus_sel       out  1   1 = DMA drives system address/data/we; 0 = CPU does
//  dma_addr      out  16  DMA address
//  dma_we        out  1   DMA write strobe
//  dma_wdata     out  8   DMA write data
//  busy          out  1   high from the cycle after the trigger until the last write completes
//  done          out  1   one-cycle pulse in the cycle after the final write
// BEHAVIOUR
//  - Reset: state=IDLE, rdy=1, bus_sel=0, dma_we=0, dma_addr=0, dma_wdata=0, busy=0, done=0, page=0, idx=0, put=0.
//  - put: parity flop, toggles every clk_ph2 edge, cleared by rst. Reads only in put==0 cycles; writes only in put==1 cycles.
//  - Outputs are Moore-decoded from registered state, page, idx and data latch.
//  - Trigger: in IDLE, cpu_we && cpu_addr==DMA_REG_ADDR at an edge latches page<=cpu_dout, idx<=0 and moves to HALT.
//  - States:
//    - IDLE: rdy=1, bus_sel=0.
//    - HALT: rdy=0, bus_sel=0; one cycle only. Next state is READ if the next cycle has put==0, else ALIGN.
//    - ALIGN: rdy=0, bus_sel=0; one cycle -> READ.
//    - READ: rdy=0, bus_sel=1, dma_we=0, dma_addr={page,idx}. At the edge, dma_wdata<=mem_rdata -> WRITE.
//    - WRITE: rdy=0, bus_sel=1, dma_we=1, dma_addr=OAM_DATA_ADDR. At the edge: if idx==BYTE_COUNT-1 -> IDLE with done=1; else idx<=idx+1 -> READ.
//  - Transfer length: 2*BYTE_COUNT bus cycles, plus 1 (HALT with put==1) or 2 (HALT with put==0).
//    - Default rdy-low duration: 513 or 514 cycles.
//  - idx is 8 bits and wraps 255->0 only at termination; page never changes mid-transfer.
//  - Writes to DMA_REG_ADDR while not IDLE are ignored (no restart, page unchanged).
//  - Trigger and done in the same cycle: the trigger is accepted, since the state is IDLE at that edge.
//  - CPU writes to any other address never affect state.
//  - rst mid-transfer: the next cycle is IDLE with rdy=1, bus_sel=0, dma_we=0. No partial done pulse; the OAM contents stay partially written.
//  - busy = (state != IDLE); done is high only in the single IDLE cycle that follows the final WRITE.
// CONFIGURATION
//  DMA_ABORT_EN defined:
//    - adds input abort (1 bit).
//    - abort seen high at any edge in HALT/ALIGN -> IDLE immediately, with done=0.
//    - abort in READ -> completes that READ and the following WRITE, then IDLE with done=1.
//    - abort in WRITE -> IDLE after that write, with done=1.
//  DMA_ABORT_EN undefined: no abort port; transfers always run to BYTE_COUNT.
// TESTING
//  1. Reset, then write 8'h02 to 16'h4014 with HALT at put==1 -> rdy low 513 cycles; reads 16'h0200..16'h02FF in order; 256 writes to 16'h2004 with data = mem_rdata; done pulse once.
//  2. Same trigger shifted one cycle (HALT at put==0) -> exactly one ALIGN cycle; rdy low 514 cycles; first READ on a put==0 cycle.
//  3. Memory model returns ~addr[7:0]; page 8'hFF -> final read 16'hFFFF; dma_wdata sequence FF,FE,...,00; idx wraps to 0 without an extra cycle.
//  4. Second write to 16'h4014 (data 8'h05) during transfer -> ignored; remaining reads stay in the original page.
//  5. rst asserted at the 100th READ -> next cycle rdy=1, bus_sel=0, busy=0, done=0; a new trigger then runs a full transfer.
//  6. DMA_ABORT_EN: abort during READ of idx 10 -> write of idx 10 occurs, then IDLE with done=1; abort in ALIGN -> no bus cycles, done=0.

Source files
------------

// File: rtl/oam_dma_controller.sv
// ---------------------------------------------------------------------------
// oam_dma_controller
//
// Sprite (OAM) DMA sequencer. A CPU write to DMA_REG_ADDR latches a source
// page, stalls the CPU through rdy and takes over the system bus. It then
// copies BYTE_COUNT bytes from {page, idx} to the PPU OAM data port at
// OAM_DATA_ADDR. Reads and writes alternate, and the bus is handed back when
// the copy is complete. The block sits between the CPU core and the system
// bus mux.
//
// Optional feature macro: DMA_ABORT_EN
//   Defined   : adds an 'abort' input that can cut a transfer short.
//   Undefined : no abort port; every transfer runs to BYTE_COUNT.
//
// Ports
//   clk_ph2    in   1   clock phase 2; all state changes on posedge
//   rst        in   1   synchronous, active-high reset
//   cpu_addr   in  16   CPU address bus
//   cpu_dout   in   8   CPU write data
//   cpu_we     in   1   CPU write strobe for the current cycle
//   mem_rdata  in   8   system bus read data, valid in the dma_addr cycle
//   abort      in   1   (DMA_ABORT_EN only) request early termination
//   rdy        out  1   0 = CPU stalled, 1 = CPU runs
//   bus_sel    out  1   1 = DMA drives system address/data/we
//   dma_addr   out 16   DMA bus address
//   dma_we     out  1   DMA write strobe
//   dma_wdata  out  8   DMA write data (byte latched by the last read)
//   busy       out  1   transfer in progress (state != IDLE)
//   done       out  1   one-cycle pulse in the cycle after the final write
// ---------------------------------------------------------------------------
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          BYTE_COUNT    = 256
) (
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic [7:0]  mem_rdata,
`ifdef DMA_ABORT_EN
  input  logic        abort,
`endif
  output logic        rdy,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic       put_reg;
  logic [7:0] page_reg, page_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] data_reg, data_next;
  logic       done_reg, done_next;
  logic       trigger;
  logic       last_write;

`ifdef DMA_ABORT_EN
  // Remembers an abort seen during READ so the paired WRITE still completes.
  logic       abort_pending_reg, abort_pending_next;
`endif

  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      state_reg <= IDLE;
      put_reg   <= 1'b0;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
      data_reg  <= 8'h00;
      done_reg  <= 1'b0;
`ifdef DMA_ABORT_EN
      abort_pending_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      // Bus phase: reads land on put==0 cycles, writes on put==1 cycles.
      put_reg   <= ~put_reg;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
`ifdef DMA_ABORT_EN
      abort_pending_reg <= abort_pending_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    last_write = (idx_reg == LAST_IDX);
`ifdef DMA_ABORT_EN
    abort_pending_next = abort_pending_reg;
    last_write = last_write || abort || abort_pending_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          page_next  = cpu_dout;
          idx_next   = 8'h00;
          state_next = HALT;
`ifdef DMA_ABORT_EN
          abort_pending_next = 1'b0;
`endif
        end
      end
      HALT: begin
        // put toggles at this edge, so put==1 now means the next cycle is a
        // read slot; otherwise burn one ALIGN cycle to reach one.
        state_next = put_reg ? READ : ALIGN;
`ifdef DMA_ABORT_EN
        if (abort) state_next = IDLE;
`endif
      end
      ALIGN: begin
        state_next = READ;
`ifdef DMA_ABORT_EN
        if (abort) state_next = IDLE;
`endif
      end
      READ: begin
        data_next  = mem_rdata;
        state_next = WRITE;
`ifdef DMA_ABORT_EN
        if (abort) abort_pending_next = 1'b1;
`endif
      end
      WRITE: begin
        if (last_write) begin
          // idx returns to zero here, which is the natural 255 -> 0 wrap
          // for a full-page transfer.
          idx_next   = 8'h00;
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef DMA_ABORT_EN
          abort_pending_next = 1'b0;
`endif
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs depend on registered state only.
    rdy       = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    bus_sel   = (state_reg == READ) || (state_reg == WRITE);
    dma_we    = (state_reg == WRITE);
    dma_wdata = data_reg;
    done      = done_reg;
    if (state_reg == READ) begin
      dma_addr = {page_reg, idx_reg};
    end else if (state_reg == WRITE) begin
      dma_addr = OAM_DATA_ADDR;
    end else begin
      dma_addr = 16'h0000;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_controller
//
// Directed bench for oam_dma_controller. Stimulus pushes the expected bus
// events (read address, write address/data, done) into a scoreboard queue;
// an independent monitor pops and compares whenever the DUT drives the bus or
// pulses done. Timing properties (rdy-low length, ALIGN insertion, reset
// response) are checked by the stimulus process against hand-derived values.
// ---------------------------------------------------------------------------
module tb_oam_dma_controller;

  logic        clk_ph2 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  mem_rdata;
  logic        rdy, bus_sel, dma_we, busy, done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
`ifdef DMA_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk_ph2 = ~clk_ph2;

  oam_dma_controller dut (
    .clk_ph2   (clk_ph2),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .mem_rdata (mem_rdata),
`ifdef DMA_ABORT_EN
    .abort     (abort),
`endif
    .rdy       (rdy),
    .bus_sel   (bus_sel),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .busy      (busy),
    .done      (done)
  );

  // Memory model: mode 0 mixes page and offset, mode 1 returns ~addr[7:0].
  logic mem_mode = 1'b0;

  function automatic logic [7:0] mem_fn(input logic [15:0] a, input logic m);
    return m ? ~a[7:0] : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  assign mem_rdata = mem_fn(dma_addr, mem_mode);

  // Independent model of the bus-phase flop.
  logic tb_put = 1'b0;
  always @(posedge clk_ph2) tb_put <= rst ? 1'b0 : ~tb_put;

  int checks = 0;
  int fails  = 0;
  int exp_low  = 0;
  int exp_lead = 0;

  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  always @(negedge clk_ph2) begin
    if (bus_sel === 1'b1 || done === 1'b1) begin
      mon_act.kind = (done === 1'b1) ? K_DONE : (dma_we ? K_WR : K_RD);
      mon_act.addr = (mon_act.kind == K_DONE) ? 16'h0000 : dma_addr;
      mon_act.data = (mon_act.kind == K_WR) ? dma_wdata : 8'h00;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: got kind=%0d addr=%04h data=%02h, expected none (t=%0t)",
                 mon_act.kind, mon_act.addr, mon_act.data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("bus_event", 32'(mon_act), 32'(mon_exp));
      end
      if (bus_sel === 1'b1) chk("bus_phase_we_vs_put", 32'(dma_we), 32'(tb_put));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (all called at a negedge)
  // -------------------------------------------------------------------------
  task automatic push_transfer(input logic [7:0] pg, input int n, input bit with_done);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e = {K_RD, pg, 8'(i), 8'h00};
      exp_q.push_back(e);
      e = {K_WR, 16'h2004, mem_fn({pg, 8'(i)}, mem_mode)};
      exp_q.push_back(e);
    end
    if (with_done) begin
      e = {K_DONE, 16'h0000, 8'h00};
      exp_q.push_back(e);
    end
  endtask

  task automatic start(input logic [7:0] pg, input int n, input bit with_done);
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_we   = 1'b1;
    // HALT gets put == ~tb_put; HALT at put==1 gives 513 stalled cycles.
    exp_low  = tb_put ? 514 : 513;
    exp_lead = tb_put ? 2 : 1;
    push_transfer(pg, n, with_done);
    $display("transfer: page=%02h bytes=%0d halt_put=%0d expect_rdy_low=%0d",
             pg, n, !tb_put, exp_low);
  endtask

  task automatic measure(input int inject_at, input int rst_at_read,
                         input bit chain, input logic [7:0] chain_pg);
    int low = 0;
    int lead = 0;
    int reads = 0;
    bit seen_bus = 1'b0;
    logic put_first = 1'b0;
    bit finished = 1'b0;
    for (int cyc = 0; cyc < 1200 && !finished; cyc++) begin
      @(negedge clk_ph2);
      cpu_we   = 1'b0;
      cpu_addr = 16'h0000;
      cpu_dout = 8'h00;
      if (rst) begin
        chk("rst_mid_transfer {rdy,bus_sel,dma_we,busy,done}",
            32'({rdy, bus_sel, dma_we, busy, done}), 32'(5'b10000));
        rst = 1'b0;
        exp_q.delete();
        finished = 1'b1;
      end else if (rdy) begin
        chk("rdy_low_cycles", 32'(low), 32'(exp_low));
        chk("halt_align_lead", 32'(lead), 32'(exp_lead));
        chk("first_read_put", 32'(put_first), 32'(0));
        chk("done_after_last_write", 32'(done), 32'(1));
        chk("busy_when_idle", 32'(busy), 32'(0));
        finished = 1'b1;
        if (chain) start(chain_pg, 256, 1'b1);
      end else begin
        low++;
        if (!bus_sel && !seen_bus) lead++;
        if (bus_sel && !seen_bus) begin
          seen_bus  = 1'b1;
          put_first = tb_put;
        end
        if (bus_sel && !dma_we) reads++;
        if (inject_at == low) begin
          cpu_addr = 16'h4014;
          cpu_dout = 8'h05;
          cpu_we   = 1'b1;
        end
        if (rst_at_read == reads && bus_sel && !dma_we) rst = 1'b1;
      end
    end
    if (!finished) begin
      checks++;
      fails++;
      $display("FAIL transfer_timeout: got no return to IDLE, expected one within 1200 cycles");
    end
  endtask

`ifdef DMA_ABORT_EN
  task automatic abort_in_read();
    int low = 0;
    bit hit = 1'b0;
    bit fin = 1'b0;
    for (int cyc = 0; cyc < 1200 && !fin; cyc++) begin
      @(negedge clk_ph2);
      cpu_we = 1'b0;
      abort  = 1'b0;
      if (rdy) begin
        chk("abort_read_low_cycles", 32'(low), 32'(exp_lead + 22));
        chk("abort_read_done", 32'(done), 32'(1));
        fin = 1'b1;
      end else begin
        low++;
        if (!hit && bus_sel && !dma_we && dma_addr[7:0] == 8'd10) begin
          abort = 1'b1;
          hit   = 1'b1;
        end
      end
    end
    if (!fin) begin
      checks++;
      fails++;
      $display("FAIL abort_read_timeout: got no return to IDLE, expected one within 1200 cycles");
    end
  endtask
`endif

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [28:0] reset_exp;
    reset_exp = {1'b1, 28'h0};
    repeat (3) @(negedge clk_ph2);
    chk("reset_state", 32'({rdy, bus_sel, dma_we, busy, done, dma_addr, dma_wdata}),
        32'(reset_exp));
    rst = 1'b0;

    // Writes elsewhere and reads of the trigger register do nothing.
    @(negedge clk_ph2);
    cpu_addr = 16'h4015; cpu_dout = 8'h09; cpu_we = 1'b1;
    @(negedge clk_ph2);
    cpu_addr = 16'h4014; cpu_we = 1'b0;
    chk("other_addr_write_ignored {rdy,busy}", 32'({rdy, busy}), 32'(2'b10));
    @(negedge clk_ph2);
    cpu_addr = 16'h0000;
    chk("reg_read_no_trigger {rdy,busy}", 32'({rdy, busy}), 32'(2'b10));

    // HALT on put==1: 513 stalled cycles.
    while (tb_put !== 1'b0) @(negedge clk_ph2);
    start(8'h02, 256, 1'b1);
    measure(-1, -1, 1'b0, 8'h00);

    // HALT on put==0: one ALIGN cycle, 514 stalled cycles.
    @(negedge clk_ph2);
    while (tb_put !== 1'b1) @(negedge clk_ph2);
    start(8'h03, 256, 1'b1);
    measure(-1, -1, 1'b0, 8'h00);

    // Retrigger mid-transfer with page 05 is ignored.
    @(negedge clk_ph2);
    start(8'h04, 256, 1'b1);
    measure(50, -1, 1'b0, 8'h00);

    // Page FF with ~addr data; retrigger in the done cycle is accepted.
    @(negedge clk_ph2);
    mem_mode = 1'b1;
    start(8'hFF, 256, 1'b1);
    measure(-1, -1, 1'b1, 8'h10);
    measure(-1, -1, 1'b0, 8'h00);

    // Reset at the 100th READ, then a full transfer.
    @(negedge clk_ph2);
    mem_mode = 1'b0;
    start(8'h07, 256, 1'b1);
    measure(-1, 100, 1'b0, 8'h00);
    @(negedge clk_ph2);
    start(8'h08, 256, 1'b1);
    measure(-1, -1, 1'b0, 8'h00);

`ifdef DMA_ABORT_EN
    // Abort during READ of idx 10: pair 10 still completes, then done.
    @(negedge clk_ph2);
    start(8'h20, 11, 1'b1);
    abort_in_read();

    // Abort in ALIGN: straight back to IDLE, no bus cycles, no done.
    @(negedge clk_ph2);
    while (tb_put !== 1'b1) @(negedge clk_ph2);
    start(8'h21, 0, 1'b0);
    @(negedge clk_ph2);
    cpu_we = 1'b0;
    chk("halt {rdy,bus_sel}", 32'({rdy, bus_sel}), 32'(2'b00));
    @(negedge clk_ph2);
    abort = 1'b1;
    chk("align {rdy,bus_sel}", 32'({rdy, bus_sel}), 32'(2'b00));
    @(negedge clk_ph2);
    abort = 1'b0;
    chk("abort_align {rdy,bus_sel,busy,done}", 32'({rdy, bus_sel, busy, done}),
        32'(4'b1000));
`endif

    repeat (4) @(negedge clk_ph2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
